// File: rtl/rtc_bus_sequencer.sv
// Drives the RTC chip's multiplexed AD bus. Each mode from the control machine
// becomes a fixed list of address/data transactions; read bursts land in datos_lectura.
module rtc_bus_sequencer #(
  parameter int unsigned T_PULSE = 10,
  parameter int unsigned T_GAP   = 5
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [1:0]  Control,
  input  logic        sync,
  input  logic [71:0] datos_escritura,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a_d,
  output logic [71:0] datos_lectura,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, NEXT, FIN} state_t;
  typedef enum logic [1:0] {
    MODE_I  = 2'b00,
    MODE_L  = 2'b01,
    MODE_E  = 2'b10,
    MODE_MS = 2'b11
  } mode_t;

  localparam logic [7:0] PULSE_LAST = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LAST   = 8'(T_GAP - 1);

  // Time/timer register map: sec, min, hour, day, month, year, tsec, tmin, thour
  function automatic logic [7:0] table_addr(input logic [3:0] k);
    logic [7:0] a;
    case (k)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      default: a = 8'h43;
    endcase
    return a;
  endfunction

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [71:0] wdata_q, wdata_d;
  logic [71:0] shadow_q, shadow_d;
  logic [71:0] rdata_q, rdata_d;
  logic        pending_q, pending_d;
  logic        just_done_q, just_done_d;

  logic [7:0]  txn_addr;
  logic [7:0]  txn_data;
  logic        txn_rd;
  logic [3:0]  last_idx;
  logic [3:0]  rd_byte;
  logic [7:0]  wbyte;

  // Decode the current transaction from the latched mode and index
  always_comb begin
    txn_addr = '0;
    txn_data = '0;
    txn_rd   = 1'b0;
    last_idx = 4'd9;
    rd_byte  = idx_q - 4'd1;
    wbyte    = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (idx_q == 4'(k)) wbyte = wdata_q[8*k +: 8];
    end
    unique case (mode_q)
      MODE_I: begin
        last_idx = 4'd2;
        case (idx_q)
          4'd0:    begin txn_addr = 8'h02; txn_data = 8'h10; end
          4'd1:    begin txn_addr = 8'h02; txn_data = 8'h00; end
          default: begin txn_addr = 8'h10; txn_data = 8'hD2; end
        endcase
      end
      MODE_L: begin
        if (idx_q == 4'd0) begin
          txn_addr = 8'hF0;
          txn_data = 8'hF0;
        end else begin
          txn_rd   = 1'b1;
          txn_addr = table_addr(rd_byte);
        end
      end
      MODE_E: begin
        if (idx_q == 4'd9) begin
          txn_addr = 8'hF1;
          txn_data = 8'hF1;
        end else begin
          txn_addr = table_addr(idx_q);
          txn_data = wbyte;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    shadow_d    = shadow_q;
    rdata_d     = rdata_q;
    pending_d   = pending_q;
    just_done_d = 1'b0;
    ad_out      = '0;
    ad_oe       = 1'b0;
    cs_n        = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    a_d         = 1'b1;
    busy        = 1'b1;
    done        = 1'b0;

    if (sync && state_q != IDLE) pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        // A status request consumes the trigger but produces no bus traffic
        if (sync || pending_q || (just_done_q && Control == MODE_L)) begin
          pending_d = 1'b0;
          if (Control != MODE_MS) begin
            state_d = ADDR;
            mode_d  = mode_t'(Control);
            wdata_d = datos_escritura;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      end
      ADDR: begin
        cs_n   = 1'b0;
        a_d    = 1'b0;
        wr_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = txn_addr;
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = GAP1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP1: begin
        cs_n = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        cs_n = 1'b0;
        if (txn_rd) begin
          rd_n = 1'b0;
        end else begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = txn_data;
        end
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = GAP2;
          if (txn_rd) begin
            for (int unsigned k = 0; k < 9; k++) begin
              if (rd_byte == 4'(k)) shadow_d[8*k +: 8] = ad_in;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP2: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      NEXT: begin
        if (idx_q == last_idx) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ADDR;
        end
      end
      FIN: begin
        done        = 1'b1;
        just_done_d = 1'b1;
        if (mode_q == MODE_L) rdata_d = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q     <= IDLE;
      mode_q      <= MODE_I;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      shadow_q    <= '0;
      rdata_q     <= '0;
      pending_q   <= 1'b0;
      just_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      rdata_q     <= rdata_d;
      pending_q   <= pending_d;
      just_done_q <= just_done_d;
    end
  end

  assign datos_lectura = rdata_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: a bus monitor decodes transactions from the pins and
// compares them with transaction lists built from the mode rules, plus a chip memory model.
module tb_rtc_bus_sequencer;
  localparam int unsigned TP = 10;
  localparam int unsigned TG = 5;

  logic        reloj = 1'b0;
  logic        resetM = 1'b1;
  logic [1:0]  Control = 2'b00;
  logic        sync = 1'b0;
  logic [71:0] datos_escritura = '0;
  logic [7:0]  ad_in = '0;
  logic [7:0]  ad_out;
  logic        ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
  logic [71:0] datos_lectura;

  always #5 reloj = ~reloj;

  rtc_bus_sequencer #(.T_PULSE(TP), .T_GAP(TG)) dut (
    .reloj(reloj), .resetM(resetM), .Control(Control), .sync(sync),
    .datos_escritura(datos_escritura), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .datos_lectura(datos_lectura),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] alen;
    logic [7:0] glen;
    logic [7:0] dlen;
  } txn_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [7:0]  chip_mem [256];
  logic [7:0]  addr_tbl [9];
  logic [71:0] exp_dl = '0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic rd, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.rd = rd; t.addr = a; t.data = rd ? 8'h00 : d;
    t.alen = 8'(TP); t.glen = 8'(TG); t.dlen = 8'(TP);
    return t;
  endfunction

  function automatic logic [71:0] predict_read();
    logic [71:0] v = '0;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = chip_mem[addr_tbl[k]];
    return v;
  endfunction

  task automatic expect_seq(input logic [1:0] mode, input logic [71:0] wd);
    exp_q.delete();
    case (mode)
      2'b00: begin
        exp_q.push_back(mk(1'b0, 8'h02, 8'h10));
        exp_q.push_back(mk(1'b0, 8'h02, 8'h00));
        exp_q.push_back(mk(1'b0, 8'h10, 8'hD2));
      end
      2'b01: begin
        exp_q.push_back(mk(1'b0, 8'hF0, 8'hF0));
        for (int k = 0; k < 9; k++) exp_q.push_back(mk(1'b1, addr_tbl[k], 8'h00));
      end
      2'b10: begin
        for (int k = 0; k < 9; k++) exp_q.push_back(mk(1'b0, addr_tbl[k], wd[8*k +: 8]));
        exp_q.push_back(mk(1'b0, 8'hF1, 8'hF1));
      end
      default: ;
    endcase
  endtask

  // Pin-level monitor and chip model: strobe runs become transactions
  int unsigned kind_prev = 0;
  int unsigned run_len = 0;
  logic [7:0]  m_addr = '0, m_data = '0, m_alen = '0, m_glen = '0, cur_addr = '0;
  logic        done_prev = 1'b0;

  always @(negedge reloj) begin
    int unsigned kind;
    if (resetM) begin
      kind_prev = 0;
      run_len   = 0;
      done_prev = 1'b0;
    end else begin
      kind = !wr_n ? (a_d ? 2 : 1) : (!rd_n ? 3 : 0);
      check_eq("strobe_overlap", 72'(!wr_n && !rd_n), 72'd0);
      check_eq("oe_rule", 72'(ad_oe), 72'(kind == 1 || kind == 2));
      check_eq("cs_during_strobe", 72'(kind != 0 && cs_n), 72'd0);
      check_eq("busy_with_cs", 72'(!cs_n && !busy), 72'd0);
      check_eq("done_one_cycle", 72'(done && done_prev), 72'd0);
      if (kind != kind_prev) begin
        case (kind_prev)
          1: m_alen = 8'(run_len);
          0: m_glen = 8'(run_len);
          default: obs_q.push_back('{kind_prev == 3, m_addr, (kind_prev == 3) ? 8'h00 : m_data,
                                     m_alen, m_glen, 8'(run_len)});
        endcase
        run_len = 1;
        if (kind == 1) begin
          m_addr   = ad_out;
          cur_addr = ad_out;
        end
        if (kind == 2) m_data = ad_out;
      end else begin
        run_len++;
      end
      kind_prev = kind;
      done_prev = done;
    end
    ad_in = chip_mem[cur_addr];
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge reloj);
  endtask

  // Waits for one sequence to finish and compares its transactions, length and result
  task automatic run_and_check(input string tag, input logic [1:0] mode,
                               input logic [71:0] wd, input bit fire);
    int unsigned base = obs_q.size();
    int unsigned busy_cycles = 0;
    int unsigned first_busy = 9999;
    int unsigned n;
    bit seen = 0;
    expect_seq(mode, wd);
    if (mode == 2'b01) exp_dl = predict_read();
    if (fire) sync = 1'b1;
    for (int unsigned c = 0; c < 2000 && !seen; c++) begin
      @(negedge reloj);
      if (c == 0) sync = 1'b0;
      if (busy) begin
        busy_cycles++;
        if (first_busy == 9999) first_busy = c;
      end
      if (done) seen = 1;
    end
    check_eq({tag, "_done_seen"}, 72'(seen), 72'd1);
    n = exp_q.size();
    check_eq({tag, "_start_latency"}, 72'(first_busy), 72'd0);
    check_eq({tag, "_busy_cycles"}, 72'(busy_cycles), 72'(n * (2 * (TP + TG) + 1) + 1));
    check_eq({tag, "_txn_count"}, 72'(obs_q.size() - base), 72'(n));
    for (int unsigned i = 0; i < n && base + i < obs_q.size(); i++)
      check_eq($sformatf("%s_txn%0d", tag, i), 72'(obs_q[base + i]), 72'(exp_q[i]));
    @(negedge reloj);
    check_eq({tag, "_done_cleared"}, 72'(done), 72'd0);
    check_eq({tag, "_idle_after_fin"}, 72'(busy), 72'd0);
    check_eq({tag, "_datos_lectura"}, datos_lectura, exp_dl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int unsigned base, cnt_strobe, cnt_done, cnt_busy;
    bit reached;
    logic [1:0]  m;
    logic [71:0] wd;
    addr_tbl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 256; i++) chip_mem[i] = 8'h00;

    tick(3);
    check_eq("rst_ad_out", 72'(ad_out), 72'd0);
    check_eq("rst_ctrl_pins", 72'({ad_oe, cs_n, rd_n, wr_n, a_d}), 72'(5'b01111));
    check_eq("rst_busy_done", 72'({busy, done}), 72'd0);
    check_eq("rst_datos_lectura", datos_lectura, 72'd0);
    resetM = 1'b0;
    tick(2);

    Control = 2'b00;
    run_and_check("init", 2'b00, '0, 1'b1);

    // Abort an L burst during its fifth read data phase
    for (int k = 0; k < 9; k++) chip_mem[addr_tbl[k]] = 8'(8'h10 + k);
    base = obs_q.size();
    Control = 2'b01;
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    Control = 2'b11;
    reached = 0;
    for (int unsigned c = 0; c < 1000 && !reached; c++) begin
      if (obs_q.size() - base >= 5 && !rd_n) reached = 1;
      else tick(1);
    end
    check_eq("reach_read5", 72'(reached), 72'd1);
    resetM = 1'b1;
    tick(1);
    check_eq("abort_pins", 72'({cs_n, rd_n, wr_n, ad_oe, busy}), 72'(5'b11100));
    check_eq("abort_datos_lectura", datos_lectura, exp_dl);
    resetM = 1'b0;
    tick(3);
    check_eq("abort_stays_idle", 72'(busy), 72'd0);

    // Continuous reading, then a pending request switches to a write burst
    Control = 2'b01;
    run_and_check("read1", 2'b01, '0, 1'b1);
    for (int k = 0; k < 9; k++) chip_mem[addr_tbl[k]] = 8'($urandom_range(0, 255));
    fork
      begin
        tick(100);
        Control = 2'b10;
        datos_escritura = 72'h090807060504030201;
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
      end
    join_none
    run_and_check("read2", 2'b01, '0, 1'b0);
    fork
      begin
        tick(60);
        datos_escritura = {$urandom, $urandom, $urandom};
      end
    join_none
    run_and_check("write_pend", 2'b10, 72'h090807060504030201, 1'b0);
    cnt_busy = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      tick(1);
      if (busy) cnt_busy++;
    end
    check_eq("no_restart_after_e", 72'(cnt_busy), 72'd0);

    // Status mode: no bus activity
    base = obs_q.size();
    Control = 2'b11;
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    cnt_strobe = 0; cnt_done = 0; cnt_busy = 0;
    for (int unsigned c = 0; c < 500; c++) begin
      tick(1);
      if (!wr_n || !rd_n || !cs_n) cnt_strobe++;
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check_eq("ms_strobes", 72'(cnt_strobe), 72'd0);
    check_eq("ms_done", 72'(cnt_done), 72'd0);
    check_eq("ms_busy", 72'(cnt_busy), 72'd0);
    check_eq("ms_txns", 72'(obs_q.size() - base), 72'd0);

    // Random modes, data and chip contents; Control moves away once latched
    for (int unsigned it = 0; it < 6; it++) begin
      m  = 2'($urandom_range(0, 2));
      wd = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 9; k++) chip_mem[addr_tbl[k]] = 8'($urandom_range(0, 255));
      datos_escritura = wd;
      Control = m;
      fork
        begin
          tick(3);
          Control = 2'b11;
          datos_escritura = ~wd;
        end
      join_none
      run_and_check($sformatf("rnd%0d", it), m, wd, 1'b1);
      tick(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
